// File: rtl/rr_mux_sched.sv
// rr_mux_sched: round-robin arbiter sharing one n-to-1 single-bit mux among n
// requesters. The captured bit is held on a valid/ready port until it is
// accepted. The winner then gets a one-hot gnt pulse.
module rr_mux_sched #(
  parameter  int unsigned n  = 32,
  localparam int unsigned SW = $clog2(n)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [n-1:0]  req_i,
  input  logic [n-1:0]  din_i,
  input  logic          out_ready_i,
  output logic          out_valid_o,
  output logic          out_data_o,
  output logic [SW-1:0] out_sel_o,
  output logic [n-1:0]  gnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [SW-1:0] LAST_IDX = SW'(n - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          data_q, data_d;
  logic          valid_q, valid_d;
  logic [SW-1:0] winner;
  logic          found;
  logic [31:0]   search_idx;
  logic          handshake;

  // Rotating-priority search: first asserted request at ptr, ptr+1, ... wrapping at n
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    search_idx = '0;
    for (int unsigned i = 0; i < n; i++) begin
      search_idx = 32'(ptr_q) + i;
      if (search_idx >= n) begin
        search_idx = search_idx - n;
      end
      if (!found && req_i[SW'(search_idx)]) begin
        found  = 1'b1;
        winner = SW'(search_idx);
      end
    end
  end

  // Reset in the same cycle suppresses completion, so no gnt is issued
  assign handshake = (state_q == BUSY) && out_ready_i && !rst_i;

  // Next-state logic: capture the winner in IDLE, release and advance ptr on handshake
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    gnt_o   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = winner;
          data_d  = din_i[winner +: 1];
          valid_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (handshake) begin
          gnt_o   = n'(1) << sel_q;
          ptr_d   = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_sel_o   = sel_q;

endmodule

// File: tb/tb_rr_mux_sched.sv
// Testbench for rr_mux_sched. Expected transfers are pushed to a queue when
// they are driven and popped when they complete.
module tb_rr_mux_sched;

  localparam int unsigned N   = 32;
  localparam int unsigned SW  = $clog2(N);
  localparam int unsigned N5  = 5;
  localparam int unsigned SW5 = $clog2(N5);

  typedef struct packed {
    logic [SW-1:0] sel;
    logic          data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // n = 32 instance
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  din;
  logic          out_ready;
  logic          out_valid;
  logic          out_data;
  logic [SW-1:0] out_sel;
  logic [N-1:0]  gnt;

  // n = 5 instance
  logic           r5_rst;
  logic [N5-1:0]  r5_req;
  logic [N5-1:0]  r5_din;
  logic           r5_rdy;
  logic           r5_valid;
  logic           r5_data;
  logic [SW5-1:0] r5_sel;
  logic [N5-1:0]  r5_gnt;

  rr_mux_sched #(.n(N)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .din_i       (din),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_sel_o   (out_sel),
    .gnt_o       (gnt)
  );

  rr_mux_sched #(.n(N5)) u_dut5 (
    .clk_i       (clk),
    .rst_i       (r5_rst),
    .req_i       (r5_req),
    .din_i       (r5_din),
    .out_ready_i (r5_rdy),
    .out_valid_o (r5_valid),
    .out_data_o  (r5_data),
    .out_sel_o   (r5_sel),
    .gnt_o       (r5_gnt)
  );

  int vec  = 0;
  int miss = 0;

  // Reference model state for the n = 32 instance
  exp_t          exp_q[$];
  logic          m_busy = 1'b0;
  logic [SW-1:0] m_ptr  = '0;
  logic [SW-1:0] m_sel  = '0;
  logic          cur_valid;
  logic          cur_hs;
  logic          cur_rst;
  logic [N-1:0]  cur_gnt;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < int'(N); i++) begin
      int k;
      k = (p + i) % int'(N);
      if (r[k]) return k;
    end
    return -1;
  endfunction

  // Apply one cycle of stimulus. Record what the DUT must show this cycle,
  // then advance the model across the next edge.
  task automatic drive(input logic r, input logic [N-1:0] rq,
                       input logic [N-1:0] d, input logic rdy);
    int w;
    rst = r; req = rq; din = d; out_ready = rdy;
    cur_rst   = r;
    cur_valid = m_busy;
    cur_hs    = m_busy && rdy && !r;
    cur_gnt   = cur_hs ? (N'(1) << m_sel) : '0;
    if (r) begin
      m_busy = 1'b0;
      m_ptr  = '0;
      exp_q.delete();
    end else if (cur_hs) begin
      m_busy = 1'b0;
      m_ptr  = (m_sel == SW'(N - 1)) ? '0 : m_sel + 1'b1;
    end else if (!m_busy) begin
      w = pick(rq, int'(m_ptr));
      if (w >= 0) begin
        m_sel  = SW'(w);
        m_busy = 1'b1;
        exp_q.push_back('{sel: SW'(w), data: d[w]});
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b1, '1, '1, 1'b1);
    @(negedge clk);
    vec++;
    if (out_valid !== 1'b0 || out_sel !== '0 || out_data !== 1'b0 || gnt !== '0) begin
      miss++;
      $display("FAIL reset_vals: valid=%0b sel=%0d data=%0b gnt=%h, want 0/0/0/0",
               out_valid, out_sel, out_data, gnt);
    end
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    vec++;
    if (out_valid !== cur_valid || gnt !== cur_gnt) begin
      miss++;
      $display("FAIL reset_idle: valid=%0b gnt=%h, want valid=%0b gnt=%h",
               out_valid, gnt, cur_valid, cur_gnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [N-1:0] rq [4];
    rq[0] = N'(1) << 5;
    rq[1] = '0;
    rq[2] = (N'(1) << 3) | (N'(1) << 6);
    rq[3] = '0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, rq[c], rq[c] | (N'(1) << 5), 1'b1);
      @(negedge clk);
      vec++;
      if (out_valid !== cur_valid || gnt !== cur_gnt) begin
        miss++;
        $display("FAIL single ctl c%0d: valid=%0b gnt=%h, want valid=%0b gnt=%h",
                 c, out_valid, gnt, cur_valid, cur_gnt);
      end
      if (c == 1) begin
        vec++;
        if (gnt !== 32'h20 || out_sel !== 5'd5 || out_data !== 1'b1) begin
          miss++;
          $display("FAIL single_grant5: gnt=%h sel=%0d data=%0b, want 00000020/5/1",
                   gnt, out_sel, out_data);
        end
      end
      if (cur_valid && !cur_rst) begin
        vec++;
        if (exp_q.size() == 0) begin
          miss++;
          $display("FAIL single sb: no expected entry, sel=%0d", out_sel);
        end else begin
          if ({out_sel, out_data} !== exp_q[0]) begin
            miss++;
            $display("FAIL single sb: sel=%0d data=%0b, want sel=%0d data=%0b",
                     out_sel, out_data, exp_q[0].sel, exp_q[0].data);
          end
          if (cur_hs) void'(exp_q.pop_front());
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    int hs_cnt;
    hs_cnt = 0;
    drive(1'b1, '0, '0, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < 66; c++) begin
      drive(1'b0, '1, 32'hA5A5A5A5, 1'b1);
      @(negedge clk);
      vec++;
      if (out_valid !== cur_valid || gnt !== cur_gnt) begin
        miss++;
        $display("FAIL rr ctl c%0d: valid=%0b gnt=%h, want valid=%0b gnt=%h",
                 c, out_valid, gnt, cur_valid, cur_gnt);
      end
      if (cur_valid && !cur_rst) begin
        vec++;
        if (exp_q.size() == 0 || {out_sel, out_data} !== exp_q[0]) begin
          miss++;
          $display("FAIL rr sb c%0d: sel=%0d data=%0b, want sel=%0d data=%0b",
                   c, out_sel, out_data, exp_q[0].sel, exp_q[0].data);
        end
        if (cur_hs) begin
          vec++;
          if (out_sel !== SW'(hs_cnt % int'(N))) begin
            miss++;
            $display("FAIL rr order: transfer %0d sel=%0d, want %0d",
                     hs_cnt, out_sel, hs_cnt % int'(N));
          end
          hs_cnt++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] d;
    logic         rdy;
    drive(1'b1, '0, '0, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < 7; c++) begin
      d   = (c % 2 == 0) ? (N'(1) << 7) : ~(N'(1) << 7);
      rdy = (c == 5);
      if (c == 0) drive(1'b0, N'(1) << 7, d, rdy);
      else if (c < 5) drive(1'b0, N'($urandom), d, rdy);
      else drive(1'b0, '0, '0, rdy);
      @(negedge clk);
      vec++;
      if (out_valid !== cur_valid || gnt !== cur_gnt) begin
        miss++;
        $display("FAIL bp ctl c%0d: valid=%0b gnt=%h, want valid=%0b gnt=%h",
                 c, out_valid, gnt, cur_valid, cur_gnt);
      end
      if (c >= 1 && c <= 5) begin
        vec++;
        if (out_valid !== 1'b1 || out_sel !== 5'd7 || out_data !== 1'b1 ||
            gnt !== ((c == 5) ? 32'h80 : 32'h0)) begin
          miss++;
          $display("FAIL bp hold c%0d: valid=%0b sel=%0d data=%0b gnt=%h, want 1/7/1/%h",
                   c, out_valid, out_sel, out_data, gnt, (c == 5) ? 32'h80 : 32'h0);
        end
      end
      if (cur_valid && !cur_rst) begin
        vec++;
        if (exp_q.size() == 0 || {out_sel, out_data} !== exp_q[0]) begin
          miss++;
          $display("FAIL bp sb c%0d: sel=%0d data=%0b, want sel=%0d data=%0b",
                   c, out_sel, out_data, exp_q[0].sel, exp_q[0].data);
        end
        if (cur_hs && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap_skip();
    logic [N-1:0] rq;
    drive(1'b1, '0, '0, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      rq = (c < 2) ? (N'(1) << 29) : ((N'(1) << 31) | (N'(1) << 2));
      drive(1'b0, rq, N'($urandom), 1'b1);
      @(negedge clk);
      vec++;
      if (out_valid !== cur_valid || gnt !== cur_gnt) begin
        miss++;
        $display("FAIL wrap ctl c%0d: valid=%0b gnt=%h, want valid=%0b gnt=%h",
                 c, out_valid, gnt, cur_valid, cur_gnt);
      end
      if (c == 3 || c == 5) begin
        vec++;
        if (out_sel !== ((c == 3) ? 5'd31 : 5'd2)) begin
          miss++;
          $display("FAIL wrap order c%0d: sel=%0d, want %0d", c, out_sel, (c == 3) ? 31 : 2);
        end
      end
      if (cur_valid && !cur_rst) begin
        vec++;
        if (exp_q.size() == 0 || {out_sel, out_data} !== exp_q[0]) begin
          miss++;
          $display("FAIL wrap sb c%0d: sel=%0d data=%0b, want sel=%0d data=%0b",
                   c, out_sel, out_data, exp_q[0].sel, exp_q[0].data);
        end
        if (cur_hs && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic         r;
    logic         rdy;
    logic [N-1:0] rq;
    drive(1'b1, '0, '0, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      r   = (c == 2);
      rdy = (c >= 2);
      rq  = (c < 3) ? (N'(1) << 3) : ((c == 3) ? ((N'(1) << 1) | (N'(1) << 3)) : '0);
      drive(r, rq, '1, rdy);
      @(negedge clk);
      vec++;
      if (out_valid !== cur_valid || gnt !== cur_gnt) begin
        miss++;
        $display("FAIL rstmid ctl c%0d: valid=%0b gnt=%h, want valid=%0b gnt=%h",
                 c, out_valid, gnt, cur_valid, cur_gnt);
      end
      if (c == 2 || c == 3) begin
        vec++;
        if (gnt !== '0 || (c == 3 && (out_valid !== 1'b0 || out_sel !== '0))) begin
          miss++;
          $display("FAIL rstmid c%0d: valid=%0b sel=%0d gnt=%h, want gnt=0 (and 0/0 after reset)",
                   c, out_valid, out_sel, gnt);
        end
      end
      if (c == 4) begin
        vec++;
        if (out_sel !== 5'd1) begin
          miss++;
          $display("FAIL rstmid search: sel=%0d, want 1", out_sel);
        end
      end
      if (cur_valid && !cur_rst) begin
        vec++;
        if (exp_q.size() == 0 || {out_sel, out_data} !== exp_q[0]) begin
          miss++;
          $display("FAIL rstmid sb c%0d: sel=%0d data=%0b, want sel=%0d data=%0b",
                   c, out_sel, out_data, exp_q[0].sel, exp_q[0].data);
        end
        if (cur_hs && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_n5();
    int   q5[$];
    logic b5;
    int   p5;
    int   s5;
    logic hs5;
    b5 = 1'b0; p5 = 0; s5 = 0;
    r5_rst = 1'b1;
    @(posedge clk); #1;
    r5_rst = 1'b0;
    r5_req = '1;
    r5_din = 5'b10110;
    r5_rdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      hs5 = b5;
      if (!b5) begin
        s5 = p5;
        q5.push_back(s5);
        b5 = 1'b1;
      end else begin
        b5 = 1'b0;
        p5 = (s5 + 1) % int'(N5);
      end
      @(negedge clk);
      vec++;
      if (r5_valid !== hs5 || r5_gnt !== (hs5 ? (N5'(1) << q5[0]) : '0)) begin
        miss++;
        $display("FAIL n5 ctl c%0d: valid=%0b gnt=%b, want valid=%0b", c, r5_valid, r5_gnt, hs5);
      end
      vec++;
      if (r5_sel > 3'd4) begin
        miss++;
        $display("FAIL n5 range c%0d: sel=%0d, want <= 4", c, r5_sel);
      end
      if (hs5) begin
        vec++;
        if (q5.size() == 0 || r5_sel !== SW5'(q5[0]) || r5_data !== r5_din[q5[0]]) begin
          miss++;
          $display("FAIL n5 sb c%0d: sel=%0d data=%0b, want sel=%0d data=%0b",
                   c, r5_sel, r5_data, q5[0], r5_din[q5[0]]);
        end
        if (q5.size() != 0) void'(q5.pop_front());
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; din = '0; out_ready = 1'b0;
    r5_rst = 1'b1; r5_req = '0; r5_din = '0; r5_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_mid();
    test_n5();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
